// File: rtl/riscv_pkg.sv
// Shared RV32 definitions: divider op encodings, XLEN and divider FSM states.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration (combinational).
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] r,
  input  logic [XLEN-1:0] q,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] r_next,
  output logic [XLEN-1:0] q_next
);

  logic [XLEN:0] r_shift;
  logic [XLEN:0] diff;

  // Shifted partial remainder kept XLEN+1 wide so divisors above 2^(XLEN-1)
  // cannot lose the top bit; diff[XLEN] is the borrow.
  always_comb begin
    r_shift = {r, q[XLEN-1]};
    diff    = r_shift - {1'b0, divisor};
    if (!diff[XLEN]) begin
      r_next = diff[XLEN-1:0];
      q_next = {q[XLEN-2:0], 1'b1};
    end else begin
      r_next = r_shift[XLEN-1:0];
      q_next = {q[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit, one quotient bit per clock.
module div_unit
  import riscv_pkg::*;
#(
  parameter int XLEN  = riscv_pkg::XLEN,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            busy
);

  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  div_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  rem_q;
  logic [XLEN-1:0]  quo_q;
  logic [XLEN-1:0]  dvs_q;
  logic [1:0]       op_q;
  logic [4:0]       rd_q;
  logic             neg_quo;
  logic             neg_rem;

  logic            is_signed;
  logic [XLEN-1:0] a_abs;
  logic [XLEN-1:0] b_abs;
  logic [XLEN-1:0] rem_step;
  logic [XLEN-1:0] quo_step;

  always_comb begin
    is_signed = !op[0];
    a_abs = (is_signed && rs1_val[XLEN-1]) ? -rs1_val : rs1_val;
    b_abs = (is_signed && rs2_val[XLEN-1]) ? -rs2_val : rs2_val;
  end

  div_step #(.XLEN(XLEN)) u_step (
    .r       (rem_q),
    .q       (quo_q),
    .divisor (dvs_q),
    .r_next  (rem_step),
    .q_next  (quo_step)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      op_q      <= '0;
      rd_q      <= '0;
      neg_quo   <= 1'b0;
      neg_rem   <= 1'b0;
      result    <= '0;
      rd_out    <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
    end else if (flush) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            op_q     <= op;
            rd_q     <= rd_in;
            neg_quo  <= is_signed && (rs1_val[XLEN-1] ^ rs2_val[XLEN-1]);
            neg_rem  <= is_signed && rs1_val[XLEN-1];
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (rs2_val == '0) begin
              result    <= op[1] ? rs1_val : '1;
              rd_out    <= rd_in;
              out_valid <= 1'b1;
              state     <= S_DONE;
            end else if (is_signed && rs1_val == MIN_INT && rs2_val == '1) begin
              result    <= op[1] ? '0 : MIN_INT;
              rd_out    <= rd_in;
              out_valid <= 1'b1;
              state     <= S_DONE;
            end else begin
              quo_q <= a_abs;
              rem_q <= '0;
              dvs_q <= b_abs;
              cnt   <= CNT_W'(XLEN-1);
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          rem_q <= rem_step;
          quo_q <= quo_step;
          cnt   <= cnt - 1'b1;
          if (cnt == '0) state <= S_FIX;
        end
        S_FIX: begin
          if (op_q[1]) result <= neg_rem ? -rem_q : rem_q;
          else         result <= neg_quo ? -quo_q : quo_q;
          rd_out    <= rd_q;
          out_valid <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: vector table plus handshake corner cases.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [4:0]  rd_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [4:0]  rd_out;
  logic        busy;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  div_unit #(.XLEN(32), .CNT_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .rs1_val   (rs1_val),
    .rs2_val   (rs2_val),
    .rd_in     (rd_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .rd_out    (rd_out),
    .busy      (busy)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Drives one request, takes the accept edge, returns at the following negedge.
  task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd);
    op = o; rs1_val = a; rs2_val = b; rd_in = rd; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Edges counted with the accept edge as edge 1; 0 means the bound expired.
  task automatic wait_valid(output int n);
    n = 1;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    if (!out_valid) n = 0;
  endtask

  task automatic do_vec(input vec_t v, input string name);
    int n;
    start_op(v.op, v.a, v.b, v.rd);
    wait_valid(n);
    check({name, " latency"}, n, v.lat);
    check({name, " result"}, result, v.exp);
    check({name, " rd_out"}, {27'd0, rd_out}, {27'd0, v.rd});
    @(posedge clk);
    @(negedge clk);
    check({name, " in_ready after"}, {31'd0, in_ready}, 32'd1);
    check({name, " out_valid after"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] held_res;
    logic        seen;

    vecs[0]  = '{2'b01, 32'd100,        32'd7,          5'd5,  32'd14,         34};
    vecs[1]  = '{2'b00, 32'hFFFF_FFF9,  32'd2,          5'd1,  32'hFFFF_FFFD,  34};
    vecs[2]  = '{2'b10, 32'hFFFF_FFF9,  32'd2,          5'd2,  32'hFFFF_FFFF,  34};
    vecs[3]  = '{2'b10, 32'd7,          32'hFFFF_FFFE,  5'd3,  32'd1,          34};
    vecs[4]  = '{2'b01, 32'h0000_1234,  32'd0,          5'd4,  32'hFFFF_FFFF,  1};
    vecs[5]  = '{2'b10, 32'hFFFF_FFFB,  32'd0,          5'd6,  32'hFFFF_FFFB,  1};
    vecs[6]  = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  5'd7,  32'h8000_0000,  1};
    vecs[7]  = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  5'd8,  32'd0,          1};
    vecs[8]  = '{2'b11, 32'd100,        32'd7,          5'd9,  32'd2,          34};
    vecs[9]  = '{2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  5'd10, 32'd1,          34};
    vecs[10] = '{2'b11, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  5'd11, 32'd1,          34};
    vecs[11] = '{2'b00, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  5'd12, 32'd14,         34};
    vecs[12] = '{2'b10, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  5'd13, 32'hFFFF_FFFE,  34};
    vecs[13] = '{2'b00, 32'h8000_0000,  32'd1,          5'd14, 32'h8000_0000,  34};
    vecs[14] = '{2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  5'd0,  32'd0,          34};
    vecs[15] = '{2'b11, 32'd5,          32'd0,          5'd31, 32'd5,          1};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; op = '0;
    rs1_val = '0; rs2_val = '0; rd_in = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    check("reset in_ready", {31'd0, in_ready}, 32'd1);
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset result", result, 32'd0);
    check("reset rd_out", {27'd0, rd_out}, 32'd0);

    for (int i = 0; i < 16; i++) begin
      do_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Backpressure: result held for 10 cycles while writeback stalls.
    out_ready = 1'b0;
    start_op(2'b01, 32'd100, 32'd7, 5'd9);
    wait_valid(n);
    check("bp latency", n, 34);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp out_valid held", {31'd0, out_valid}, 32'd1);
      check("bp result held", result, 32'd14);
      check("bp rd_out held", {27'd0, rd_out}, 32'd9);
      check("bp in_ready low", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp release in_ready", {31'd0, in_ready}, 32'd1);
    check("bp release out_valid", {31'd0, out_valid}, 32'd0);
    start_op(2'b01, 32'd9, 32'd3, 5'd3);
    check("bp next accepted busy", {31'd0, busy}, 32'd1);
    wait_valid(n);
    check("bp next result", result, 32'd3);
    @(posedge clk);
    @(negedge clk);

    // Flush while IDLE with a valid request: must not be accepted.
    flush = 1'b1; in_valid = 1'b1; op = 2'b01; rs1_val = 32'd50; rs2_val = 32'd5; rd_in = 5'd2;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    check("idle flush busy", {31'd0, busy}, 32'd0);
    check("idle flush in_ready", {31'd0, in_ready}, 32'd1);

    // Flush during CALC: no result ever emitted.
    start_op(2'b01, 32'd1000, 32'd10, 5'd20);
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    check("flush in_ready", {31'd0, in_ready}, 32'd1);
    check("flush busy", {31'd0, busy}, 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (out_valid) seen = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    check("flush no out_valid", {31'd0, seen}, 32'd0);
    do_vec('{2'b01, 32'd9, 32'd3, 5'd21, 32'd3, 34}, "post-flush");

    // Reset during CALC: all outputs back to reset values.
    held_res = result;
    check("pre-reset result nonzero", {31'd0, (held_res != 32'd0)}, 32'd1);
    start_op(2'b01, 32'd1000, 32'd10, 5'd22);
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("midreset in_ready", {31'd0, in_ready}, 32'd1);
    check("midreset out_valid", {31'd0, out_valid}, 32'd0);
    check("midreset busy", {31'd0, busy}, 32'd0);
    check("midreset result", result, 32'd0);
    check("midreset rd_out", {27'd0, rd_out}, 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (out_valid) seen = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    check("midreset no out_valid", {31'd0, seen}, 32'd0);
    do_vec('{2'b00, 32'd9, 32'd3, 5'd23, 32'd3, 34}, "post-reset");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
